// File: rtl/pci_rr_arbiter.sv
// Round-robin central arbiter for an 8-master PCI bus: rotating priority,
// grant timeout, and a forced one-cycle turnaround between grants.
module pci_rr_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] REQ,
  input  logic       FRAME,
  input  logic       IRDY,
  output logic [7:0] GNT,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       bus_idle,
  output logic       timeout_pulse,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [2:0] last_q;
  logic [7:0] timer_q;
  logic       frame_q;
  logic [7:0] gnt_q;
  logic [2:0] grant_id_q;
  logic       grant_valid_q;
  logic       bus_idle_q;
  logic       timeout_pulse_q;

  logic [2:0] winner;
  logic       any_req;
  logic       other_req;
  logic [7:0] own_mask;

  // Search starts one past the last owner so the previous winner is lowest priority.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = 3'd0;
    found  = 1'b0;
    idx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!found && !REQ[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req   = ~&REQ;
  assign own_mask  = 8'b1 << grant_id_q;
  assign other_req = |(~REQ & ~own_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_q          <= 3'd7;
      timer_q         <= 8'd0;
      frame_q         <= 1'b1;
      gnt_q           <= 8'hFF;
      grant_id_q      <= 3'd0;
      grant_valid_q   <= 1'b0;
      bus_idle_q      <= 1'b1;
      timeout_pulse_q <= 1'b0;
    end else begin
      frame_q         <= FRAME;
      bus_idle_q      <= FRAME & IRDY;
      timeout_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Granting while the bus is still busy is deliberate (hidden arbitration).
          if (any_req) begin
            gnt_q         <= ~(8'b1 << winner);
            grant_id_q    <= winner;
            grant_valid_q <= 1'b1;
            timer_q       <= 8'd0;
            state_q       <= GRANT;
          end else begin
            gnt_q         <= 8'hFF;
            grant_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (!FRAME && frame_q) begin
            last_q  <= grant_id_q;
            state_q <= BUSY;
          end else if (REQ[grant_id_q]) begin
            gnt_q         <= 8'hFF;
            grant_valid_q <= 1'b0;
            state_q       <= TURN;
          end else if (timer_q == TIMER_MAX) begin
            gnt_q           <= 8'hFF;
            grant_valid_q   <= 1'b0;
            timeout_pulse_q <= 1'b1;
            last_q          <= grant_id_q;
            state_q         <= TURN;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        BUSY: begin
          // A competing request only removes GNT; the owner still finishes.
          if (FRAME && IRDY) begin
            gnt_q         <= 8'hFF;
            grant_valid_q <= 1'b0;
            state_q       <= TURN;
          end else if (other_req) begin
            gnt_q         <= 8'hFF;
            grant_valid_q <= 1'b0;
          end
        end
        TURN: begin
          gnt_q         <= 8'hFF;
          grant_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          gnt_q         <= 8'hFF;
          grant_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign GNT           = gnt_q;
  assign grant_id      = grant_id_q;
  assign grant_valid   = grant_valid_q;
  assign bus_idle      = bus_idle_q;
  assign timeout_pulse = timeout_pulse_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_pci_rr_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       frame;
  logic       irdy;
  logic [7:0] gnt;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       bus_idle;
  logic       timeout_pulse;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  pci_rr_arbiter #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .REQ          (req),
    .FRAME        (frame),
    .IRDY         (irdy),
    .GNT          (gnt),
    .grant_id     (grant_id),
    .grant_valid  (grant_valid),
    .bus_idle     (bus_idle),
    .timeout_pulse(timeout_pulse),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_free();
    frame = 1'b1;
    irdy  = 1'b1;
  endtask

  initial begin
    logic [2:0] m;
    logic [7:0] exp_gnt;

    rst_n = 1'b0;
    req   = 8'hFF;
    bus_free();

    // Reset state
    @(negedge clk);
    chk("rst_gnt", gnt, 8'hFF);
    chk("rst_id", grant_id, 3'd0);
    chk("rst_gv", grant_valid, 1'b0);
    chk("rst_idle", bus_idle, 1'b1);
    chk("rst_to", timeout_pulse, 1'b0);
    chk("rst_state", state, S_IDLE);
    rst_n = 1'b1;
    step();

    // Single master 0 transaction
    req = 8'hFE;
    step();
    chk("t1_gnt", gnt, 8'hFE);
    chk("t1_gv", grant_valid, 1'b1);
    chk("t1_id", grant_id, 3'd0);
    chk("t1_state", state, S_GRANT);
    frame = 1'b0; irdy = 1'b0;
    step();
    chk("t1_busy_gnt", gnt, 8'hFE);
    chk("t1_busy_state", state, S_BUSY);
    req = 8'hFF; frame = 1'b1;
    step();
    chk("t1_last_phase_gnt", gnt, 8'hFE);
    chk("t1_bus_idle_low", bus_idle, 1'b0);
    irdy = 1'b1;
    step();
    chk("t1_turn_gnt", gnt, 8'hFF);
    chk("t1_turn_gv", grant_valid, 1'b0);
    chk("t1_turn_state", state, S_TURN);
    step();
    chk("t1_idle_state", state, S_IDLE);
    chk("t1_idle_bus", bus_idle, 1'b1);

    // All masters requesting: rotation 1..7 then wrap to 0 (last owner was 0)
    req = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m = 3'((i + 1) % 8);
      exp_gnt = 8'hFF ^ (8'h01 << m);
      step();
      chk("rr_gnt", gnt, exp_gnt);
      chk("rr_id", grant_id, m);
      frame = 1'b0; irdy = 1'b0;
      step();
      chk("rr_busy_gnt", gnt, exp_gnt);
      frame = 1'b1;
      step();
      chk("rr_preempt_gnt", gnt, 8'hFF);
      irdy = 1'b1;
      step();
      chk("rr_turn_gnt", gnt, 8'hFF);
      step();
      chk("rr_gap_gnt", gnt, 8'hFF);
      chk("rr_gap_state", state, S_IDLE);
    end
    req = 8'hFF;
    step();

    // Timeout: masters 3 and 4 request, 3 wins, FRAME never falls
    req = 8'hE7;
    step();
    chk("to_first_gnt", gnt, 8'hF7);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("to_hold_gnt", gnt, 8'hF7);
      chk("to_hold_pulse", timeout_pulse, 1'b0);
    end
    step();
    chk("to_revoke_gnt", gnt, 8'hFF);
    chk("to_pulse", timeout_pulse, 1'b1);
    chk("to_state", state, S_TURN);
    step();
    chk("to_pulse_once", timeout_pulse, 1'b0);
    chk("to_idle_gnt", gnt, 8'hFF);
    step();
    chk("to_next_gnt", gnt, 8'hEF);
    chk("to_next_id", grant_id, 3'd4);
    req = 8'hFF;
    step();
    chk("wd_gnt", gnt, 8'hFF);
    chk("wd_pulse", timeout_pulse, 1'b0);
    chk("wd_state", state, S_TURN);
    step();

    // Preemption: master 5 busy, master 2 requests
    req = 8'hDF;
    step();
    chk("pe_gnt", gnt, 8'hDF);
    frame = 1'b0; irdy = 1'b0;
    step();
    chk("pe_busy_gnt", gnt, 8'hDF);
    req = 8'hDB;
    step();
    chk("pe_revoke_gnt", gnt, 8'hFF);
    chk("pe_id", grant_id, 3'd5);
    chk("pe_state", state, S_BUSY);
    req = 8'hFB; frame = 1'b1;
    step();
    chk("pe_last_gnt", gnt, 8'hFF);
    chk("pe_still_busy", state, S_BUSY);
    irdy = 1'b1;
    step();
    chk("pe_turn", state, S_TURN);
    step();
    chk("pe_idle_gnt", gnt, 8'hFF);
    chk("pe_idle_state", state, S_IDLE);
    step();
    chk("pe_m2_gnt", gnt, 8'hFB);
    chk("pe_m2_id", grant_id, 3'd2);
    req = 8'hFF;
    step();
    step();

    // FRAME already low when the grant arrives does not count as a start
    frame = 1'b0; irdy = 1'b0;
    req = 8'hBF;
    step();
    chk("fl_gnt", gnt, 8'hBF);
    step();
    chk("fl_no_busy", state, S_GRANT);
    bus_free();
    step();
    chk("fl_hold_gnt", gnt, 8'hBF);
    chk("fl_hold_state", state, S_GRANT);
    frame = 1'b0;
    step();
    chk("fl_busy", state, S_BUSY);
    chk("fl_busy_gnt", gnt, 8'hBF);
    req = 8'hFF; bus_free();
    step();
    chk("fl_turn_gnt", gnt, 8'hFF);
    step();

    // FRAME falls exactly on the timeout cycle: BUSY wins, no pulse
    req = 8'hFD;
    step();
    chk("ft_gnt", gnt, 8'hFD);
    chk("ft_id", grant_id, 3'd1);
    for (int k = 1; k < 16; k++) step();
    chk("ft_pre_gnt", gnt, 8'hFD);
    frame = 1'b0; irdy = 1'b0;
    step();
    chk("ft_gnt_kept", gnt, 8'hFD);
    chk("ft_no_pulse", timeout_pulse, 1'b0);
    chk("ft_state", state, S_BUSY);
    req = 8'hFF; bus_free();
    step();
    step();

    // Asynchronous reset in the middle of a transaction
    req = 8'hFB;
    step();
    chk("ar_gnt", gnt, 8'hFB);
    frame = 1'b0; irdy = 1'b0;
    step();
    chk("ar_busy", state, S_BUSY);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt_now", gnt, 8'hFF);
    chk("ar_pulse_now", timeout_pulse, 1'b0);
    chk("ar_gv_now", grant_valid, 1'b0);
    chk("ar_id_now", grant_id, 3'd0);
    chk("ar_state_now", state, S_IDLE);
    @(negedge clk);
    req = 8'h00; bus_free();
    rst_n = 1'b1;
    step();
    chk("ar_first_gnt", gnt, 8'hFE);
    chk("ar_first_id", grant_id, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pci_rr_arbiter.md
# pci_rr_arbiter

Round-robin central arbiter for the 8-master PCI bus, replacing arrival-order granting with fair rotating priority, grant timeout and a mandatory turnaround cycle. Samples the active-low REQ lines and the bus state (FRAME, IRDY) on every rising clock edge and drives one-hot active-low GNT. It sits between the master request wires and the shared bus, and is the only block that drives GNT.

## Interface
- TIMEOUT, 16: clocks a granted master has to start FRAME before its grant is revoked; legal 2..255.
- clk  in  1  bus clock; all sampling and outputs on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- REQ  in  8  active-low request, bit i = master i.
- FRAME  in  1  active-low PCI FRAME.
- IRDY  in  1  active-low PCI IRDY.
- GNT  out  8  active-low grant; at most one bit low at any time.
- grant_id  out  3  index of the master currently or last granted.
- grant_valid  out  1  high when any GNT bit is low.
- bus_idle  out  1  registered (FRAME & IRDY).
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked for timeout.

## Operation
- All outputs registered. Internal state: fsm, last[2:0], timer (8 bits), frame_q (previous sampled FRAME).
- Reset (async, any time, including mid-transaction): GNT=8'hFF, grant_id=0, grant_valid=0, bus_idle=1, timeout_pulse=0, fsm=IDLE, last=7, timer=0, frame_q=1.
- Winner: first i with REQ[i]=0, searching (last+1) mod 8 upward with wrap; after reset master 0 is highest priority.
- IDLE: GNT=FF. If any REQ low -> GNT[winner]=0, grant_id=winner, timer=0, -> GRANT. Grant is issued even if the bus is busy (hidden arbitration).
- GRANT, priority order each cycle:
  1. FRAME=0 and frame_q=1 (falling edge): last=grant_id, -> BUSY; GNT held.
  2. REQ[grant_id]=1 (master withdrew): GNT=FF, -> TURN; last unchanged.
  3. timer==TIMEOUT-1: GNT=FF, timeout_pulse=1, last=grant_id (revoked master loses priority), -> TURN.
  4. Otherwise timer+1.
- BUSY: if any REQ[j]=0 with j!=grant_id, GNT=FF (preempt; owner finishes its transaction). When FRAME=1 and IRDY=1 are sampled (bus idle): GNT=FF, -> TURN.
- TURN: GNT=FF for exactly one cycle, -> IDLE.
- grant_valid = ~&GNT (registered alongside GNT). grant_id holds its value outside GRANT/BUSY.
- TRDY is ignored; bus completion is decided by FRAME/IRDY only.

## Timing
- Request latency: REQ low sampled at edge N in IDLE -> GNT low after edge N; with the bus idle, earliest FRAME is sampled at edge N+1.
- Back-to-back grants: minimum one all-high GNT cycle (TURN) plus one IDLE cycle between grants to different masters, so GNT never switches directly from one master to another.
- Timeout: GNT stays low for exactly TIMEOUT cycles if FRAME never falls; timeout_pulse is high in the cycle GNT returns to FF.
- Simultaneous events in GRANT: FRAME falling and timeout in the same cycle -> BUSY, no pulse. FRAME falling and REQ withdrawal in the same cycle -> BUSY.
- A FRAME already low when GRANT is entered (another master's transaction) does not start BUSY; only a high-to-low transition does.
- Timer never exceeds TIMEOUT-1 and does not wrap.

## Test plan
- Reset then REQ=8'hFE: GNT=8'hFE one cycle after sampling, grant_valid=1. Drive FRAME low, then FRAME/IRDY high -> GNT=FF, then IDLE.
- REQ=8'h00 held, each master completes a 2-cycle transaction: grant order 0,1,2,...,7,0 with grant_id matching, and an all-FF GNT gap before every new grant.
- REQ[3] low and FRAME never asserted, TIMEOUT=16: GNT=8'hF7 for exactly 16 cycles, then timeout_pulse=1 with GNT=FF; next grant goes to master 4 if it is requesting.
- Master 5 in BUSY, REQ[2] goes low: GNT=FF next cycle while FRAME stays low; master 2 is granted only after idle, TURN and IDLE.
- rst_n pulsed low mid-BUSY: GNT=FF and timeout_pulse=0 immediately (asynchronous); after release, REQ=8'h00 -> master 0 granted first.
- In GRANT, FRAME falls on the timeout cycle: -> BUSY, no timeout_pulse, GNT stays asserted.
